// File: rtl/dffram_ahbl_banked_if.sv
`default_nettype none
// ============================================================================
// Module   : dffram_ahbl_banked_if
// Purpose  : AHB-Lite slave-side bus bundle for the banked DFFRAM bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface dffram_ahbl_banked_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/dffram_ahbl_banked.sv
`default_nettype none
// ============================================================================
// Module   : dffram_ahbl_banked
// Purpose  : Zero-wait AHB-Lite bridge to NUM_BANKS DFFRAM macros with a
//            one-entry posted-write buffer and byte-merged read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module dffram_ahbl_banked #(
  parameter  int BANK_WORDS = 512,
  parameter  int NUM_BANKS  = 2,
  localparam int WA         = $clog2(BANK_WORDS),
  localparam int BA         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  dffram_ahbl_banked_if.slave     ahb,
  output logic [NUM_BANKS-1:0]    RAM_EN,
  output logic [3:0]              RAM_WE,
  output logic [WA-1:0]           RAM_A,
  output logic [31:0]             RAM_DI,
  input  logic [32*NUM_BANKS-1:0] RAM_DO
);

  localparam int                   BW      = (BA > 0) ? BA : 1;
  localparam logic [NUM_BANKS-1:0] BANK_ONE = NUM_BANKS'(1);
  localparam logic [1:0]           ST_OKAY = 2'd0;
  localparam logic [1:0]           ST_ERR1 = 2'd1;
  localparam logic [1:0]           ST_ERR2 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          ap_valid, ap_bad, ap_err, ap_rd, ap_wr;
  logic [BW-1:0] ap_bank;
  logic [WA-1:0] ap_word;
  logic [3:0]    ap_mask;

  logic          wr_dp_q, wr_dp_d;
  logic [BW-1:0] wr_bank_q, wr_bank_d;
  logic [WA-1:0] wr_word_q, wr_word_d;
  logic [3:0]    wr_mask_q, wr_mask_d;
  logic          rd_dp_q, rd_dp_d;
  logic [BW-1:0] rd_bank_q, rd_bank_d;
  logic          hit_q, hit_d;
  logic          buf_valid_q, buf_valid_d;
  logic [BW-1:0] buf_bank_q, buf_bank_d;
  logic [WA-1:0] buf_word_q, buf_word_d;
  logic [3:0]    buf_mask_q, buf_mask_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic          drain;
  logic [31:0]   ram_do_sel, rd_merged;
  logic          hreadyout, hresp;
  logic          unused_inputs;

  assign ap_valid = HRESETn & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign ap_word  = ahb.HADDR[WA+1:2];
  assign ap_err   = ap_valid & ap_bad;
  assign ap_rd    = ap_valid & ~ap_bad & ~ahb.HWRITE;
  assign ap_wr    = ap_valid & ~ap_bad & ahb.HWRITE;
  assign unused_inputs = ^{ahb.HADDR[31:WA+BA+2], ahb.HTRANS[0]};

  generate
    if (BA > 0) begin : g_bank_sel
      assign ap_bank = ahb.HADDR[WA+BA+1:WA+2];
    end else begin : g_bank_single
      assign ap_bank = '0;
    end
  endgenerate

  always_comb begin
    ap_mask = 4'b0000;
    ap_bad  = 1'b0;
    case (ahb.HSIZE)
      3'd0: ap_mask = 4'b0001 << ahb.HADDR[1:0];
      3'd1: begin
        ap_mask = 4'b0011 << ahb.HADDR[1:0];
        ap_bad  = ahb.HADDR[0];
      end
      3'd2: begin
        ap_mask = 4'b1111;
        ap_bad  = |ahb.HADDR[1:0];
      end
      default: ap_bad = 1'b1;
    endcase
  end

  // Error response: one stalled cycle, then a ready cycle, both flagged ERROR.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_OKAY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_OKAY;
    case (state_q)
      ST_OKAY: state_d = ap_err ? ST_ERR1 : ST_OKAY;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ap_err ? ST_ERR1 : ST_OKAY;
      default: state_d = ST_OKAY;
    endcase
  end

  always_comb begin
    hreadyout = (state_q != ST_ERR1);
    hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  end

  // Reads own the RAM port; otherwise a valid buffer entry drains.
  always_comb begin
    drain  = buf_valid_q & ~ap_rd;
    RAM_EN = '0;
    RAM_WE = 4'b0000;
    RAM_A  = buf_word_q;
    RAM_DI = buf_data_q;
    if (ap_rd) begin
      RAM_EN = BANK_ONE << ap_bank;
      RAM_A  = ap_word;
    end else if (buf_valid_q) begin
      RAM_EN = BANK_ONE << buf_bank_q;
      RAM_WE = buf_mask_q;
    end
  end

  always_comb begin
    ram_do_sel = RAM_DO[31:0];
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_bank_q == BW'(b)) ram_do_sel = RAM_DO[32*b +: 32];
    end
    for (int l = 0; l < 4; l++) begin
      rd_merged[8*l +: 8] = (hit_q & buf_mask_q[l]) ? buf_data_q[8*l +: 8]
                                                    : ram_do_sel[8*l +: 8];
    end
    hrdata_d = rd_dp_q ? rd_merged : hrdata_q;
  end

  // The hit is judged against what the buffer will hold during the data phase:
  // an in-flight write replaces the entry, otherwise the entry is kept.
  always_comb begin
    wr_dp_d   = ap_wr;
    wr_bank_d = ap_wr ? ap_bank : wr_bank_q;
    wr_word_d = ap_wr ? ap_word : wr_word_q;
    wr_mask_d = ap_wr ? ap_mask : wr_mask_q;
    rd_dp_d   = ap_rd;
    rd_bank_d = ap_rd ? ap_bank : rd_bank_q;
    hit_d     = ap_rd & (wr_dp_q ? ((wr_bank_q == ap_bank) && (wr_word_q == ap_word))
                                 : (buf_valid_q && (buf_bank_q == ap_bank) &&
                                    (buf_word_q == ap_word)));
    buf_valid_d = buf_valid_q & ~drain;
    buf_bank_d  = buf_bank_q;
    buf_word_d  = buf_word_q;
    buf_mask_d  = buf_mask_q;
    buf_data_d  = buf_data_q;
    if (wr_dp_q) begin
      buf_valid_d = 1'b1;
      buf_bank_d  = wr_bank_q;
      buf_word_d  = wr_word_q;
      buf_mask_d  = wr_mask_q;
      buf_data_d  = ahb.HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_dp_q     <= 1'b0;
      wr_bank_q   <= '0;
      wr_word_q   <= '0;
      wr_mask_q   <= 4'b0000;
      rd_dp_q     <= 1'b0;
      rd_bank_q   <= '0;
      hit_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_bank_q  <= '0;
      buf_word_q  <= '0;
      buf_mask_q  <= 4'b0000;
      buf_data_q  <= 32'h0;
      hrdata_q    <= 32'h0;
    end else begin
      wr_dp_q     <= wr_dp_d;
      wr_bank_q   <= wr_bank_d;
      wr_word_q   <= wr_word_d;
      wr_mask_q   <= wr_mask_d;
      rd_dp_q     <= rd_dp_d;
      rd_bank_q   <= rd_bank_d;
      hit_q       <= hit_d;
      buf_valid_q <= buf_valid_d;
      buf_bank_q  <= buf_bank_d;
      buf_word_q  <= buf_word_d;
      buf_mask_q  <= buf_mask_d;
      buf_data_q  <= buf_data_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign ahb.HREADYOUT = hreadyout;
  assign ahb.HRESP     = hresp;
  assign ahb.HRDATA    = hrdata_d;

endmodule
`default_nettype wire

// File: tb/tb_dffram_ahbl_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_dffram_ahbl_banked
// Purpose  : Directed vector bench for dffram_ahbl_banked with a DFFRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dffram_ahbl_banked;

  localparam int BANK_WORDS = 512;
  localparam int NB         = 2;
  localparam int WA         = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NB-1:0]   ram_en;
  logic [3:0]      ram_we;
  logic [WA-1:0]   ram_a;
  logic [31:0]     ram_di;
  logic [32*NB-1:0] ram_do;
  logic [31:0]     mem [NB][BANK_WORDS];

  int tests = 0;
  int fails = 0;

  dffram_ahbl_banked_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  dffram_ahbl_banked #(.BANK_WORDS(BANK_WORDS), .NUM_BANKS(NB)) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .ahb    (bus),
    .RAM_EN (ram_en),
    .RAM_WE (ram_we),
    .RAM_A  (ram_a),
    .RAM_DI (ram_di),
    .RAM_DO (ram_do)
  );

  always #5 clk = ~clk;

  // Single-port macro model: read data appears the cycle after an enabled access.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_en[b]) begin
        for (int l = 0; l < 4; l++)
          if (ram_we[l]) mem[b][ram_a][8*l +: 8] <= ram_di[8*l +: 8];
        ram_do[32*b +: 32] <= mem[b][ram_a];
      end
    end
  end

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        resp;
    logic [1:0]  en;
    logic [3:0]  we;
    logic [8:0]  a;
    logic [31:0] di;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                              input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rdy, input logic resp,
                              input logic [1:0] en, input logic [3:0] we, input logic [8:0] a,
                              input logic [31:0] di, input logic [31:0] rd);
    vec_t v;
    v = '{sel, trans, wr, size, addr, wdata, rdy, resp, en, we, a, di, rd};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.HSEL   = v.sel;
    bus.HTRANS = v.trans;
    bus.HWRITE = v.wr;
    bus.HSIZE  = v.size;
    bus.HADDR  = v.addr;
    bus.HWDATA = v.wdata;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_vec(input int idx, input vec_t v);
    logic ok;
    ok = (bus.HREADYOUT === v.rdy) && (bus.HRESP === v.resp) && (ram_en === v.en) &&
         (ram_we === v.we) && (bus.HRDATA === v.rd) &&
         ((v.en == 2'b00) || (ram_a === v.a)) && ((v.we == 4'h0) || (ram_di === v.di));
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL vec%0d: got rdy=%b resp=%b en=%b we=%h a=%h di=%h rd=%h expected rdy=%b resp=%b en=%b we=%h a=%h di=%h rd=%h",
               idx, bus.HREADYOUT, bus.HRESP, ram_en, ram_we, ram_a, ram_di, bus.HRDATA,
               v.rdy, v.resp, v.en, v.we, v.a, v.di, v.rd);
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < BANK_WORDS; w++) mem[b][w] = 32'h0;
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // sel trans wr size addr wdata | rdy resp en we a di rd
    vecs.push_back(mk(1, 2, 1, 2, 32'h4,   32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'hDEADBEEF, 1, 0, 2'b00, 4'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 2'b01, 4'hF, 1, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(1, 2, 0, 2, 32'h4,   32'h0,        1, 0, 2'b01, 4'h0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2, 1, 2, 32'h8,   32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 2, 0, 2, 32'h8,   32'h11223344, 1, 0, 2'b01, 4'h0, 2, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 2'b01, 4'hF, 2, 32'h11223344, 32'h11223344));
    vecs.push_back(mk(1, 2, 1, 2, 32'h10,  32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'h11223344));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'hAAAAAAAA, 1, 0, 2'b00, 4'h0, 0, 0, 32'h11223344));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 2'b01, 4'hF, 4, 32'hAAAAAAAA, 32'h11223344));
    vecs.push_back(mk(1, 2, 1, 0, 32'h12,  32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'h11223344));
    vecs.push_back(mk(1, 2, 0, 2, 32'h10,  32'h00550000, 1, 0, 2'b01, 4'h0, 4, 0, 32'h11223344));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 2'b01, 4'h4, 4, 32'h00550000, 32'hAA55AAAA));
    vecs.push_back(mk(1, 2, 1, 1, 32'h1,   32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'hAA55AAAA));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        0, 1, 2'b00, 4'h0, 0, 0, 32'hAA55AAAA));
    vecs.push_back(mk(1, 2, 0, 2, 32'h2,   32'h0,        1, 1, 2'b00, 4'h0, 0, 0, 32'hAA55AAAA));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        0, 1, 2'b00, 4'h0, 0, 0, 32'hAA55AAAA));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 1, 2'b00, 4'h0, 0, 0, 32'hAA55AAAA));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'hAA55AAAA));
    vecs.push_back(mk(1, 2, 1, 2, 32'h800, 32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'hAA55AAAA));
    vecs.push_back(mk(1, 2, 0, 2, 32'h0,   32'hCAFEF00D, 1, 0, 2'b01, 4'h0, 0, 0, 32'hAA55AAAA));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 2'b10, 4'hF, 0, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1, 2, 0, 2, 32'h800, 32'h0,        1, 0, 2'b10, 4'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 2, 1, 2, 32'hC,   32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0BADC0DE, 1, 0, 2'b00, 4'h0, 0, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 2, 0, 2, 32'hC,   32'h0,        1, 0, 2'b01, 4'h0, 3, 0, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 2'b01, 4'hF, 3, 32'h0BADC0DE, 32'h0BADC0DE));
    vecs.push_back(mk(1, 1, 1, 2, 32'h4,   32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'h0BADC0DE));
    vecs.push_back(mk(0, 2, 0, 2, 32'h4,   32'h0,        1, 0, 2'b00, 4'h0, 0, 0, 32'h0BADC0DE));

    @(negedge clk);
    #1;
    chk("reset_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    chk("reset_hresp",     32'(bus.HRESP),     32'h0);
    chk("reset_hrdata",    bus.HRDATA,         32'h0);
    chk("reset_ram_en_we", 32'({ram_en, ram_we}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_vec(i, vecs[i]);
    end

    // Reset while a posted write is waiting to drain.
    @(negedge clk);
    drive(mk(1, 2, 1, 2, 32'h14, 32'h0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 32'h0, 32'h12345678, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_reset_drain_we", 32'(ram_we), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("midrst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    chk("midrst_hresp",     32'(bus.HRESP),     32'h0);
    chk("midrst_hrdata",    bus.HRDATA,         32'h0);
    chk("midrst_ram_en_we", 32'({ram_en, ram_we}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("post_reset_no_write", 32'({ram_en, ram_we}), 32'h0);
    end
    @(negedge clk);
    drive(mk(1, 2, 0, 2, 32'h14, 32'h0, 1, 0, 0, 0, 0, 0, 0));
    #1;
    chk("post_reset_read_en", 32'({ram_en, ram_we}), 32'h10);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0));
    #1;
    chk("post_reset_read_data", bus.HRDATA, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
